// File: rtl/mem_stage_pkg.sv
// Shared definitions for the pipeline memory stage: FSM encoding and default bus timeout.
package mem_stage_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam int unsigned DEFAULT_CNT_W   = 5;

endpackage

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results to Writeback, or runs one load/store on the data bus,
// stalling upstream until ack or timeout abort.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_readmem,
    input  logic        ex_mem_writemem,
    input  logic [31:0] ex_mem_regb,
    input  logic        ex_mem_selwsource,
    input  logic [4:0]  ex_mem_regdest,
    input  logic        ex_mem_writereg,
    input  logic [31:0] ex_mem_wbvalue,
    output logic        mem_stall,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_read,
    output logic        dmem_write,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [4:0]  mem_wb_regdest,
    output logic        mem_wb_writereg,
    output logic [31:0] mem_wb_wbvalue,
    output logic        mem_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       dmem_addr_q, dmem_addr_d;
    logic [31:0]       dmem_wdata_q, dmem_wdata_d;
    logic              dmem_read_q, dmem_read_d;
    logic              dmem_write_q, dmem_write_d;
    logic [4:0]        wb_regdest_q, wb_regdest_d;
    logic              wb_writereg_q, wb_writereg_d;
    logic [31:0]       wb_wbvalue_q, wb_wbvalue_d;
    logic              mem_err_q, mem_err_d;
    logic              mem_req;

    assign mem_req = ex_mem_readmem | ex_mem_writemem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            dmem_read_q   <= 1'b0;
            dmem_write_q  <= 1'b0;
            wb_regdest_q  <= '0;
            wb_writereg_q <= 1'b0;
            wb_wbvalue_q  <= '0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            dmem_read_q   <= dmem_read_d;
            dmem_write_q  <= dmem_write_d;
            wb_regdest_q  <= wb_regdest_d;
            wb_writereg_q <= wb_writereg_d;
            wb_wbvalue_q  <= wb_wbvalue_d;
            mem_err_q     <= mem_err_d;
        end
    end

    // Next state, bus control and Writeback bundle; stall releases on the completing edge.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        dmem_read_d   = dmem_read_q;
        dmem_write_d  = dmem_write_q;
        wb_regdest_d  = wb_regdest_q;
        wb_writereg_d = wb_writereg_q;
        wb_wbvalue_d  = wb_wbvalue_q;
        mem_err_d     = 1'b0;
        mem_stall     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    mem_stall     = 1'b1;
                    wb_writereg_d = 1'b0;
                    dmem_addr_d   = ex_mem_wbvalue;
                    dmem_wdata_d  = ex_mem_regb;
                    dmem_write_d  = ex_mem_writemem;
                    dmem_read_d   = ex_mem_readmem & ~ex_mem_writemem;
                    cnt_d         = '0;
                    state_d       = ST_BUSY;
                end else begin
                    wb_regdest_d  = ex_mem_regdest;
                    wb_writereg_d = ex_mem_writereg;
                    wb_wbvalue_d  = ex_mem_wbvalue;
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    wb_regdest_d  = ex_mem_regdest;
                    wb_writereg_d = ex_mem_writereg;
                    wb_wbvalue_d  = ex_mem_selwsource ? dmem_rdata : ex_mem_wbvalue;
                    dmem_read_d   = 1'b0;
                    dmem_write_d  = 1'b0;
                    state_d       = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_err_d     = 1'b1;
                    wb_writereg_d = 1'b0;
                    dmem_read_d   = 1'b0;
                    dmem_write_d  = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    mem_stall     = 1'b1;
                    wb_writereg_d = 1'b0;
                    cnt_d         = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dmem_addr       = dmem_addr_q;
    assign dmem_wdata      = dmem_wdata_q;
    assign dmem_read       = dmem_read_q;
    assign dmem_write      = dmem_write_q;
    assign mem_wb_regdest  = wb_regdest_q;
    assign mem_wb_writereg = wb_writereg_q;
    assign mem_wb_wbvalue  = wb_wbvalue_q;
    assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model.
module tb_mem_stage;

    localparam int unsigned TO = 4;

    logic        clock;
    logic        reset;
    logic        ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg;
    logic [31:0] ex_mem_regb, ex_mem_wbvalue;
    logic [4:0]  ex_mem_regdest;
    logic        mem_stall, dmem_read, dmem_write, dmem_ack, mem_wb_writereg, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_wb_wbvalue;
    logic [4:0]  mem_wb_regdest;

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clock(clock), .reset(reset),
        .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
        .ex_mem_regb(ex_mem_regb), .ex_mem_selwsource(ex_mem_selwsource),
        .ex_mem_regdest(ex_mem_regdest), .ex_mem_writereg(ex_mem_writereg),
        .ex_mem_wbvalue(ex_mem_wbvalue), .mem_stall(mem_stall),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_wb_regdest(mem_wb_regdest), .mem_wb_writereg(mem_wb_writereg),
        .mem_wb_wbvalue(mem_wb_wbvalue), .mem_err(mem_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an outstanding transaction and how many bus cycles it has been waiting.
    bit          m_busy;
    int          m_age;
    logic [31:0] e_addr, e_wdata, e_wbvalue;
    logic        e_read, e_write, e_writereg, e_err;
    logic [4:0]  e_regdest;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_age <= 0;
            e_addr <= 0; e_wdata <= 0; e_read <= 0; e_write <= 0;
            e_regdest <= 0; e_writereg <= 0; e_wbvalue <= 0; e_err <= 0;
        end else begin
            e_err <= 0;
            if (!m_busy) begin
                if (ex_mem_readmem || ex_mem_writemem) begin
                    m_busy     <= 1;
                    m_age      <= 1;
                    e_writereg <= 0;
                    e_addr     <= ex_mem_wbvalue;
                    e_wdata    <= ex_mem_regb;
                    e_write    <= ex_mem_writemem;
                    e_read     <= ex_mem_readmem && !ex_mem_writemem;
                end else begin
                    e_regdest  <= ex_mem_regdest;
                    e_writereg <= ex_mem_writereg;
                    e_wbvalue  <= ex_mem_wbvalue;
                end
            end else if (dmem_ack) begin
                m_busy     <= 0;
                e_regdest  <= ex_mem_regdest;
                e_writereg <= ex_mem_writereg;
                e_wbvalue  <= ex_mem_selwsource ? dmem_rdata : ex_mem_wbvalue;
                e_read     <= 0;
                e_write    <= 0;
            end else if (m_age == int'(TO)) begin
                m_busy     <= 0;
                e_err      <= 1;
                e_writereg <= 0;
                e_read     <= 0;
                e_write    <= 0;
            end else begin
                m_age      <= m_age + 1;
                e_writereg <= 0;
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        logic exp_stall;
        exp_stall = m_busy ? !(dmem_ack || m_age == int'(TO))
                           : (ex_mem_readmem || ex_mem_writemem);
        chk("stall",    32'(mem_stall),       32'(exp_stall));
        chk("addr",     dmem_addr,            e_addr);
        chk("wdata",    dmem_wdata,           e_wdata);
        chk("read",     32'(dmem_read),       32'(e_read));
        chk("write",    32'(dmem_write),      32'(e_write));
        chk("regdest",  32'(mem_wb_regdest),  32'(e_regdest));
        chk("writereg", 32'(mem_wb_writereg), 32'(e_writereg));
        chk("wbvalue",  mem_wb_wbvalue,       e_wbvalue);
        chk("err",      32'(mem_err),         32'(e_err));
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        ex_mem_readmem = 0; ex_mem_writemem = 0; ex_mem_regb = 0; ex_mem_selwsource = 0;
        ex_mem_regdest = 0; ex_mem_writereg = 0; ex_mem_wbvalue = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic issue_load(input logic [31:0] addr, input logic [4:0] rd);
        ex_mem_readmem = 1; ex_mem_writemem = 0; ex_mem_wbvalue = addr;
        ex_mem_selwsource = 1; ex_mem_regdest = rd; ex_mem_writereg = 1; dmem_ack = 0;
    endtask

    initial begin
        logic held;
        idle_inputs();
        reset = 0;
        repeat (3) @(posedge clock);
        #2 reset = 1;
        @(negedge clock);
        chk("rst_wbvalue", mem_wb_wbvalue, 32'h0);
        chk("rst_read",    32'(dmem_read), 32'h0);
        chk("rst_err",     32'(mem_err),   32'h0);

        // ALU pass-through
        cyc();
        ex_mem_wbvalue = 32'h1234; ex_mem_regdest = 5'd5; ex_mem_writereg = 1;
        @(negedge clock); chk("alu_stall", 32'(mem_stall), 32'h0);
        cyc();
        @(negedge clock);
        chk("alu_wbvalue",  mem_wb_wbvalue,        32'h1234);
        chk("alu_regdest",  32'(mem_wb_regdest),   32'h5);
        chk("alu_writereg", 32'(mem_wb_writereg),  32'h1);

        // Load acked in the third bus cycle
        cyc(); issue_load(32'h100, 5'd7);
        @(negedge clock); chk("ld_stall_issue", 32'(mem_stall), 32'h1);
        cyc();
        @(negedge clock);
        chk("ld_read", 32'(dmem_read), 32'h1);
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_bubble", 32'(mem_wb_writereg), 32'h0);
        cyc(); cyc();
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clock); chk("ld_stall_ack", 32'(mem_stall), 32'h0);
        cyc(); idle_inputs();
        @(negedge clock);
        chk("ld_wbvalue",  mem_wb_wbvalue,       32'hDEADBEEF);
        chk("ld_regdest",  32'(mem_wb_regdest),  32'h7);
        chk("ld_writereg", 32'(mem_wb_writereg), 32'h1);
        chk("ld_read_off", 32'(dmem_read),       32'h0);

        // Store with read also set (store wins), acked in first bus cycle
        cyc();
        ex_mem_writemem = 1; ex_mem_readmem = 1; ex_mem_wbvalue = 32'h200; ex_mem_regb = 32'hCAFE;
        cyc(); dmem_ack = 1;
        @(negedge clock);
        chk("st_write", 32'(dmem_write), 32'h1);
        chk("st_read",  32'(dmem_read),  32'h0);
        chk("st_wdata", dmem_wdata,      32'hCAFE);
        chk("st_addr",  dmem_addr,       32'h200);
        chk("st_stall", 32'(mem_stall),  32'h0);
        cyc(); idle_inputs();
        @(negedge clock);
        chk("st_write_off", 32'(dmem_write),      32'h0);
        chk("st_writereg",  32'(mem_wb_writereg), 32'h0);

        // Timeout abort after TO bus cycles
        cyc(); issue_load(32'h300, 5'd3);
        cyc(); cyc(); cyc(); cyc();
        @(negedge clock);
        chk("to_last_read", 32'(dmem_read), 32'h1);
        chk("to_last_err",  32'(mem_err),   32'h0);
        cyc(); idle_inputs();
        @(negedge clock);
        chk("to_err",      32'(mem_err),         32'h1);
        chk("to_writereg", 32'(mem_wb_writereg), 32'h0);
        chk("to_read",     32'(dmem_read),       32'h0);
        cyc();
        @(negedge clock); chk("to_err_once", 32'(mem_err), 32'h0);

        // Ack on the final allowed cycle wins over timeout
        cyc(); issue_load(32'h304, 5'd4);
        cyc(); cyc(); cyc(); cyc();
        dmem_ack = 1; dmem_rdata = 32'h55AA;
        cyc(); idle_inputs();
        @(negedge clock);
        chk("late_err",      32'(mem_err),         32'h0);
        chk("late_wbvalue",  mem_wb_wbvalue,       32'h55AA);
        chk("late_writereg", 32'(mem_wb_writereg), 32'h1);

        // Reset mid-access, then a stray ack
        cyc(); issue_load(32'h400, 5'd9);
        cyc();
        reset = 0;
        #1 chk("rst_async_read", 32'(dmem_read), 32'h0);
        cyc(); idle_inputs(); dmem_ack = 1; dmem_rdata = 32'hBAD0BAD0;
        cyc(); reset = 1;
        cyc(); dmem_ack = 0;
        @(negedge clock);
        chk("stray_wbvalue", mem_wb_wbvalue, 32'h0);
        chk("stray_read",    32'(dmem_read), 32'h0);
        ex_mem_wbvalue = 32'hABCD; ex_mem_regdest = 5'd9; ex_mem_writereg = 1;
        cyc();
        @(negedge clock);
        chk("post_rst_wbvalue", mem_wb_wbvalue, 32'hABCD);
        idle_inputs();

        // Random traffic; ex_mem_* held while stalled, advanced otherwise
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            held = mem_stall;
            cyc();
            if (!held) begin
                int kind;
                kind = int'($urandom_range(0, 3));
                ex_mem_readmem    = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
                ex_mem_writemem   = (kind == 2) || (kind == 3);
                ex_mem_regb       = $urandom;
                ex_mem_selwsource = 1'($urandom_range(0, 1));
                ex_mem_regdest    = 5'($urandom);
                ex_mem_writereg   = 1'($urandom_range(0, 1));
                ex_mem_wbvalue    = $urandom;
            end
            dmem_ack   = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
        end

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
